// File: rtl/kbd_pkg.sv
// Shared types and constants for the PS/2 key buffer: receiver states,
// key_data field positions and the CPU address region code of the key port.
package kbd_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } rx_state_e;

   localparam int HEAD_LSB     = 0;
   localparam int NONEMPTY_BIT = 8;
   localparam int OVERFLOW_BIT = 9;

   localparam logic [11:0] KEY_REGION = 12'h003;

endpackage

// File: rtl/ps2_key_buffer_if.sv
// CPU-facing key port of the PS/2 key buffer, plus the receiver state for observation.
interface ps2_key_buffer_if;
   // read_key is a level strobe held while the key region is addressed; the
   // buffer pops once on its rising edge. key_data is always valid and shows the
   // current head, so no ready/valid pair is needed in either direction.
   logic                read_key;
   logic [31:0]         key_data;
   kbd_pkg::rx_state_e  rx_state;

   modport master (output read_key, input key_data, input rx_state);
   modport slave  (input read_key, output key_data, output rx_state);
endinterface

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: pad synchronizers, falling-edge detect, frame FSM with
// timeout. Odd-parity checking is enabled by defining PS2_PARITY_CHK_EN.
module ps2_rx
   import kbd_pkg::*;
#(
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] rx_byte,
   output logic       rx_valid,
   output rx_state_e  state
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);

`ifdef PS2_PARITY_CHK_EN
   localparam bit PARITY_CHK = 1'b1;
`else
   localparam bit PARITY_CHK = 1'b0;
`endif

   logic [1:0]    clk_sync;
   logic [1:0]    data_sync;
   logic          clk_q;
   logic          fall;
   logic          s_data;
   rx_state_e     state_n;
   logic [2:0]    bit_cnt, bit_cnt_n;
   logic [7:0]    shift, shift_n;
   logic          parity, parity_n;
   logic [TW-1:0] tmo, tmo_n;
   logic          push_n;
   logic          frame_ok;

   assign fall     = clk_q & ~clk_sync[1];
   assign s_data   = data_sync[1];
   assign frame_ok = !PARITY_CHK || (^{shift, parity});

   always_ff @(posedge clk) begin
      if (rst) begin
         clk_sync  <= 2'b11;
         data_sync <= 2'b11;
         clk_q     <= 1'b1;
         state     <= IDLE;
         bit_cnt   <= '0;
         shift     <= '0;
         parity    <= 1'b0;
         tmo       <= '0;
         rx_valid  <= 1'b0;
         rx_byte   <= '0;
      end else begin
         clk_sync  <= {clk_sync[0], ps2_clk};
         data_sync <= {data_sync[0], ps2_data};
         clk_q     <= clk_sync[1];
         state     <= state_n;
         bit_cnt   <= bit_cnt_n;
         shift     <= shift_n;
         parity    <= parity_n;
         tmo       <= tmo_n;
         rx_valid  <= push_n;
         if (push_n) rx_byte <= shift;
      end
   end

   always_comb begin
      state_n   = state;
      bit_cnt_n = bit_cnt;
      shift_n   = shift;
      parity_n  = parity;
      push_n    = 1'b0;
      tmo_n     = (state == IDLE || fall) ? '0 : tmo + TW'(1);
      // A stalled partial frame is abandoned once the silence reaches TIMEOUT_CYC.
      if (state != IDLE && !fall && tmo == TW'(TIMEOUT_CYC - 1)) begin
         state_n = IDLE;
         tmo_n   = '0;
      end else if (fall) begin
         case (state)
            IDLE: begin
               if (!s_data) begin
                  state_n   = DATA;
                  bit_cnt_n = '0;
               end
            end
            DATA: begin
               shift_n   = {s_data, shift[7:1]};
               bit_cnt_n = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) state_n = PARITY;
            end
            PARITY: begin
               parity_n = s_data;
               state_n  = STOP;
            end
            STOP: begin
               push_n  = s_data & frame_ok;
               state_n = IDLE;
            end
            default: state_n = IDLE;
         endcase
      end
   end

endmodule

// File: rtl/ps2_key_buffer.sv
// PS/2 key buffer top: receiver plus scan-code FIFO read by the CPU key port.
// Optional odd-parity frame check is controlled by the PS2_PARITY_CHK_EN macro.
module ps2_key_buffer
   import kbd_pkg::*;
#(
   parameter int DEPTH       = 8,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ps2_clk,
   input  logic             ps2_data,
   ps2_key_buffer_if.slave  bus
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          overflow;
   logic          read_key_q;
   logic [7:0]    rx_byte;
   logic          rx_valid;
   rx_state_e     rx_state;
   logic          pop_evt, do_pop, do_push, drop, empty, full;
   logic [7:0]    head;

   ps2_rx #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
      .clk      (clk),
      .rst      (rst),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .rx_byte  (rx_byte),
      .rx_valid (rx_valid),
      .state    (rx_state)
   );

   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   assign pop_evt = bus.read_key & ~read_key_q;
   assign do_pop  = pop_evt & ~empty;
   // A pop frees the slot a same-cycle push needs, so full only drops without one.
   assign do_push = rx_valid & (~full | do_pop);
   assign drop    = rx_valid & full & ~do_pop;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         overflow   <= 1'b0;
         read_key_q <= 1'b0;
      end else begin
         read_key_q <= bus.read_key;
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW + 1)'(1);
            2'b01:   count <= count - (AW + 1)'(1);
            default: count <= count;
         endcase
         if (drop)         overflow <= 1'b1;
         else if (pop_evt) overflow <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= rx_byte;
   end

   assign head = empty ? 8'h00 : mem[rd_ptr];

   always_comb begin
      bus.key_data                       = '0;
      bus.key_data[HEAD_LSB +: 8]        = head;
      bus.key_data[NONEMPTY_BIT]         = ~empty;
      bus.key_data[OVERFLOW_BIT]         = overflow;
   end

   assign bus.rx_state = rx_state;

endmodule

// File: tb/tb_ps2_key_buffer.sv
// Directed bench for ps2_key_buffer: frame reception, pop edge, overflow,
// simultaneous push/pop when full, parity handling, timeout and mid-frame reset.
module tb_ps2_key_buffer;
   import kbd_pkg::*;

   localparam int DEPTH = 8;
   localparam int TMO   = 200;
   localparam int HALF  = 20;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ps2_clk = 1'b1;
   logic ps2_data = 1'b1;
   int   total = 0;
   int   bad = 0;

   ps2_key_buffer_if bus();

   ps2_key_buffer #(.DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
      .clk      (clk),
      .rst      (rst),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic ps2_bit(input logic v);
      ps2_data = v;
      repeat (HALF) tick();
      ps2_clk = 1'b0;
      repeat (HALF) tick();
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic par);
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(b[i]);
      ps2_bit(par);
      ps2_bit(1'b1);
      repeat (HALF) tick();
   endtask

   task automatic do_reset;
      rst = 1'b1;
      bus.read_key = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_reset;
      do_reset();
      total++;
      if (bus.key_data !== 32'h0) begin
         bad++;
         $display("FAIL reset_key_data: got %h want %h", bus.key_data, 32'h0);
      end
      total++;
      if (bus.rx_state !== IDLE) begin
         bad++;
         $display("FAIL reset_state: got %0d want %0d", bus.rx_state, IDLE);
      end
   endtask

   task automatic test_frame_latency;
      logic [7:0] b;
      b = 8'h1C;
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(b[i]);
      ps2_bit(1'b0);
      ps2_data = 1'b1;
      repeat (HALF) tick();
      ps2_clk = 1'b0;
      repeat (3) tick();
      total++;
      if (bus.key_data !== 32'h0) begin
         bad++;
         $display("FAIL latency_early: got %h want %h", bus.key_data, 32'h0);
      end
      tick();
      total++;
      if (bus.key_data !== 32'h0000_011C) begin
         bad++;
         $display("FAIL latency_visible: got %h want %h", bus.key_data, 32'h0000_011C);
      end
      repeat (HALF - 4) tick();
      ps2_clk = 1'b1;
      repeat (HALF) tick();
   endtask

   task automatic test_held_pop;
      bus.read_key = 1'b1;
      #1;
      total++;
      if (bus.key_data !== 32'h0000_011C) begin
         bad++;
         $display("FAIL pop_same_cycle: got %h want %h", bus.key_data, 32'h0000_011C);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         total++;
         if (bus.key_data !== 32'h0) begin
            bad++;
            $display("FAIL pop_held_%0d: got %h want %h", i, bus.key_data, 32'h0);
         end
      end
      tick();
      bus.read_key = 1'b0;
      tick();
   endtask

   task automatic test_overflow;
      logic [31:0] exp;
      do_reset();
      for (int i = 1; i <= 9; i++) send_frame(8'(i), ~^(8'(i)));
      total++;
      if (bus.key_data !== 32'h0000_0301) begin
         bad++;
         $display("FAIL ovf_after_9: got %h want %h", bus.key_data, 32'h0000_0301);
      end
      for (int i = 1; i <= 8; i++) begin
         exp = (i == 1) ? 32'h0000_0301 : (32'h0000_0100 | 32'(i));
         bus.read_key = 1'b1;
         #1;
         total++;
         if (bus.key_data !== exp) begin
            bad++;
            $display("FAIL ovf_read_%0d: got %h want %h", i, bus.key_data, exp);
         end
         repeat (3) tick();
         bus.read_key = 1'b0;
         tick();
      end
      total++;
      if (bus.key_data !== 32'h0) begin
         bad++;
         $display("FAIL ovf_drained: got %h want %h", bus.key_data, 32'h0);
      end
   endtask

   task automatic test_back_to_back;
      logic [7:0]  b;
      logic [31:0] exp;
      do_reset();
      for (int i = 0; i < DEPTH; i++) send_frame(8'h11 + 8'(i), ~^(8'h11 + 8'(i)));
      b = 8'h99;
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(b[i]);
      ps2_bit(~^b);
      ps2_data = 1'b1;
      repeat (HALF) tick();
      ps2_clk = 1'b0;
      repeat (3) tick();
      bus.read_key = 1'b1;
      #1;
      total++;
      if (bus.key_data !== 32'h0000_0111) begin
         bad++;
         $display("FAIL full_head: got %h want %h", bus.key_data, 32'h0000_0111);
      end
      tick();
      bus.read_key = 1'b0;
      total++;
      if (bus.key_data !== 32'h0000_0112) begin
         bad++;
         $display("FAIL full_simul: got %h want %h", bus.key_data, 32'h0000_0112);
      end
      repeat (HALF - 4) tick();
      ps2_clk = 1'b1;
      repeat (HALF) tick();
      for (int i = 0; i < DEPTH; i++) begin
         exp = (i == DEPTH - 1) ? 32'h0000_0199 : (32'h0000_0112 + 32'(i));
         bus.read_key = 1'b1;
         #1;
         total++;
         if (bus.key_data !== exp) begin
            bad++;
            $display("FAIL full_drain_%0d: got %h want %h", i, bus.key_data, exp);
         end
         tick();
         bus.read_key = 1'b0;
         tick();
      end
      total++;
      if (bus.key_data !== 32'h0) begin
         bad++;
         $display("FAIL full_empty: got %h want %h", bus.key_data, 32'h0);
      end
   endtask

   task automatic test_parity;
      logic [31:0] exp;
`ifdef PS2_PARITY_CHK_EN
      exp = 32'h0;
`else
      exp = 32'h0000_011C;
`endif
      do_reset();
      send_frame(8'h1C, 1'b1);
      total++;
      if (bus.key_data !== exp) begin
         bad++;
         $display("FAIL parity_bad_frame: got %h want %h", bus.key_data, exp);
      end
   endtask

   task automatic test_timeout;
      logic [7:0] b;
      do_reset();
      b = 8'hF3;
      ps2_bit(1'b0);
      for (int i = 0; i < 4; i++) ps2_bit(b[i]);
      total++;
      if (bus.rx_state !== DATA) begin
         bad++;
         $display("FAIL tmo_partial_state: got %0d want %0d", bus.rx_state, DATA);
      end
      repeat (TMO + 10) tick();
      total++;
      if (bus.rx_state !== IDLE) begin
         bad++;
         $display("FAIL tmo_idle: got %0d want %0d", bus.rx_state, IDLE);
      end
      send_frame(8'h5A, ~^(8'h5A));
      total++;
      if (bus.key_data !== 32'h0000_015A) begin
         bad++;
         $display("FAIL tmo_next_frame: got %h want %h", bus.key_data, 32'h0000_015A);
      end
      bus.read_key = 1'b1;
      tick();
      bus.read_key = 1'b0;
      tick();
      total++;
      if (bus.key_data !== 32'h0) begin
         bad++;
         $display("FAIL tmo_single_entry: got %h want %h", bus.key_data, 32'h0);
      end
   endtask

   task automatic test_reset_mid_frame;
      do_reset();
      send_frame(8'h22, ~^(8'h22));
      ps2_bit(1'b0);
      ps2_bit(1'b1);
      ps2_bit(1'b0);
      do_reset();
      total++;
      if (bus.key_data !== 32'h0) begin
         bad++;
         $display("FAIL rst_mid_flush: got %h want %h", bus.key_data, 32'h0);
      end
      total++;
      if (bus.rx_state !== IDLE) begin
         bad++;
         $display("FAIL rst_mid_state: got %0d want %0d", bus.rx_state, IDLE);
      end
      send_frame(8'h1C, 1'b0);
      total++;
      if (bus.key_data !== 32'h0000_011C) begin
         bad++;
         $display("FAIL rst_mid_next: got %h want %h", bus.key_data, 32'h0000_011C);
      end
   endtask

   initial begin
      bus.read_key = 1'b0;
      test_reset();
      test_frame_latency();
      test_held_pop();
      test_overflow();
      test_back_to_back();
      test_parity();
      test_timeout();
      test_reset_mid_frame();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
